// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // 2'd3 is unused and treated as IDLE by the FSM.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fs_cell.sv
// Combinational full subtractor: d = x - y - bin, bout set when a borrow is needed.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor a - b, LSB first, one bit per clock, reusing one fs_cell.
// Handshake: start is honoured only in IDLE/DONE; busy marks RUN; done pulses one cycle with diff/borrow valid.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    // Only the WIDTH-1 already-computed bits are stored; the final bit joins them at the last edge.
    logic [WIDTH-2:0] sr_q, sr_d;
    logic             bin_q, bin_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             bit_d;
    logic             bit_bo;
    logic             load;

    fs_cell u_fs (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (bin_q),
        .d    (bit_d),
        .bout (bit_bo)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sr_d     = sr_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        busy     = 1'b0;
        done     = 1'b0;
        load     = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        case (state_q)
            S_IDLE: begin
            end
            S_RUN: begin
                busy  = 1'b1;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = (sr_q >> 1) | ((WIDTH-1)'(bit_d) << (WIDTH - 2));
                bin_d = bit_bo;
                if (count_q == LAST) begin
                    diff_d   = {bit_d, sr_q};
                    borrow_d = bit_bo;
                    state_d  = S_DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            sa_d    = a;
            sb_d    = b;
            bin_d   = 1'b0;
            count_d = '0;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sr_q     <= sr_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
